// File: rtl/usb_cdc_stream_bridge_if.sv
// Signal bundle between the USB CDC core, the bridge and the chip-side app pins.
// The slave modport is the bridge's view; master is the view of whatever drives it.
interface usb_cdc_stream_bridge_if #(
    parameter int OUT_DEPTH = 8,
    parameter int IN_DEPTH  = 8
);
    logic                       configured_i;
    logic [7:0]                 core_out_data_i;
    logic                       core_out_valid_i;
    logic                       core_out_ready_o;
    logic [7:0]                 app_out_data_o;
    logic                       app_out_valid_o;
    logic                       app_out_ready_i;
    logic [7:0]                 app_in_data_i;
    logic                       app_in_valid_i;
    logic                       app_in_ready_o;
    logic [7:0]                 core_in_data_o;
    logic                       core_in_valid_o;
    logic                       core_in_ready_i;
    logic [$clog2(OUT_DEPTH):0] out_level_o;
    logic [$clog2(IN_DEPTH):0]  in_level_o;

    modport slave (
        input  configured_i,
        input  core_out_data_i, core_out_valid_i, app_out_ready_i,
        input  app_in_data_i, app_in_valid_i, core_in_ready_i,
        output core_out_ready_o, app_out_data_o, app_out_valid_o,
        output app_in_ready_o, core_in_data_o, core_in_valid_o,
        output out_level_o, in_level_o
    );

    modport master (
        output configured_i,
        output core_out_data_i, core_out_valid_i, app_out_ready_i,
        output app_in_data_i, app_in_valid_i, core_in_ready_i,
        input  core_out_ready_o, app_out_data_o, app_out_valid_o,
        input  app_in_ready_o, core_in_data_o, core_in_valid_o,
        input  out_level_o, in_level_o
    );
endinterface

// File: rtl/usb_cdc_stream_bridge.sv
// Buffered byte-stream bridge between the CDC core and the app pins.
// OUT (host->app) is a plain FWFT FIFO; IN (app->host) is a FIFO whose output
// is gated by a drain FSM so the host sees full packets instead of single bytes.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_HOLD  | collecting IN bytes; core_in_valid_o held low
// S_DRAIN | offering IN bytes to the core until the FIFO runs empty
module usb_cdc_stream_bridge #(
    parameter int OUT_DEPTH    = 8,
    parameter int IN_DEPTH     = 8,
    parameter int IN_BURST     = 8,
    parameter int IDLE_TIMEOUT = 4800
) (
    input logic                    clk_i,
    input logic                    rstn_i,
    usb_cdc_stream_bridge_if.slave bus
);

    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int IAW = $clog2(IN_DEPTH);
    // One spare code above IDLE_TIMEOUT keeps the counter wide enough even for 0/1.
    localparam int ICW = $clog2(IDLE_TIMEOUT + 2);

    localparam logic [OAW:0]   O_ONE      = {{OAW{1'b0}}, 1'b1};
    localparam logic [IAW:0]   I_ONE      = {{IAW{1'b0}}, 1'b1};
    localparam logic [IAW:0]   BURST_LVL  = (IAW + 1)'(IN_BURST);
    localparam logic [ICW-1:0] IDLE_ONE   = {{(ICW - 1){1'b0}}, 1'b1};
    localparam logic [ICW-1:0] IDLE_LAST  = ICW'(IDLE_TIMEOUT > 0 ? IDLE_TIMEOUT - 1 : 0);
    localparam bit             TIMEOUT_ON = (IDLE_TIMEOUT != 0);

    typedef enum logic {
        S_HOLD,
        S_DRAIN
    } state_t;

    logic [7:0]     out_mem [OUT_DEPTH];
    logic [OAW:0]   out_wr;
    logic [OAW:0]   out_rd;
    logic [OAW:0]   out_level;
    logic           out_full;
    logic           out_empty;
    logic           out_push;
    logic           out_pop;

    logic [7:0]     in_mem [IN_DEPTH];
    logic [IAW:0]   in_wr;
    logic [IAW:0]   in_rd;
    logic [IAW:0]   in_level;
    logic           in_full;
    logic           in_empty;
    logic           in_push;
    logic           in_pop;

    state_t         state;
    logic [ICW-1:0] idle_cnt;

    // OUT FIFO status; outputs are forced low while the core is unconfigured.
    assign out_level            = out_wr - out_rd;
    assign out_empty            = (out_wr == out_rd);
    assign out_full             = (out_wr[OAW] != out_rd[OAW]) &&
                                  (out_wr[OAW-1:0] == out_rd[OAW-1:0]);
    assign bus.core_out_ready_o = !out_full && bus.configured_i;
    assign bus.app_out_valid_o  = !out_empty && bus.configured_i;
    assign bus.app_out_data_o   = out_mem[out_rd[OAW-1:0]];
    assign bus.out_level_o      = out_level;
    assign out_push             = bus.core_out_valid_i && bus.core_out_ready_o;
    assign out_pop              = bus.app_out_valid_o && bus.app_out_ready_i;

    // IN FIFO status; the core only sees data while draining.
    assign in_level             = in_wr - in_rd;
    assign in_empty             = (in_wr == in_rd);
    assign in_full              = (in_wr[IAW] != in_rd[IAW]) &&
                                  (in_wr[IAW-1:0] == in_rd[IAW-1:0]);
    assign bus.app_in_ready_o   = !in_full && bus.configured_i;
    assign bus.core_in_valid_o  = !in_empty && (state == S_DRAIN) && bus.configured_i;
    assign bus.core_in_data_o   = in_mem[in_rd[IAW-1:0]];
    assign bus.in_level_o       = in_level;
    assign in_push              = bus.app_in_valid_i && bus.app_in_ready_o;
    assign in_pop               = bus.core_in_valid_o && bus.core_in_ready_i;

    // OUT FIFO storage and pointers; unconfigured drops all queued bytes.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_wr <= '0;
            out_rd <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) out_mem[i] <= '0;
        end else if (!bus.configured_i) begin
            out_wr <= '0;
            out_rd <= '0;
        end else begin
            if (out_push) begin
                out_mem[out_wr[OAW-1:0]] <= bus.core_out_data_i;
                out_wr                   <= out_wr + O_ONE;
            end
            if (out_pop) out_rd <= out_rd + O_ONE;
        end
    end

    // IN FIFO storage and pointers; unconfigured drops all queued bytes.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            in_wr <= '0;
            in_rd <= '0;
            for (int i = 0; i < IN_DEPTH; i++) in_mem[i] <= '0;
        end else if (!bus.configured_i) begin
            in_wr <= '0;
            in_rd <= '0;
        end else begin
            if (in_push) begin
                in_mem[in_wr[IAW-1:0]] <= bus.app_in_data_i;
                in_wr                  <= in_wr + I_ONE;
            end
            if (in_pop) in_rd <= in_rd + I_ONE;
        end
    end

    // Drain FSM with its idle counter: release a burst on threshold or app silence.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= S_HOLD;
            idle_cnt <= '0;
        end else if (!bus.configured_i) begin
            state    <= S_HOLD;
            idle_cnt <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (in_push || in_empty) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + IDLE_ONE;
                    end
                    if ((in_level >= BURST_LVL) ||
                        (TIMEOUT_ON && (idle_cnt == IDLE_LAST) && !in_empty)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    idle_cnt <= '0;
                    // Leave only when the final byte goes out and nothing new arrives.
                    if (in_empty || ((in_level == I_ONE) && in_pop && !in_push)) begin
                        state <= S_HOLD;
                    end
                end
                default: begin
                    state    <= S_HOLD;
                    idle_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_cdc_stream_bridge.sv
// Directed bench for usb_cdc_stream_bridge: a per-cycle vector table for the OUT
// fill/empty sequence, then hand sequences for IN threshold, IN timeout, random
// wrap traffic against queue models, and a mid-drain flush.
module tb_usb_cdc_stream_bridge;

    localparam int OD = 8;
    localparam int ID = 8;
    localparam int IB = 8;
    localparam int IT = 16;
    localparam int NXFER = 40;

    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;

    always #5 clk_i = ~clk_i;

    usb_cdc_stream_bridge_if #(.OUT_DEPTH(OD), .IN_DEPTH(ID)) bus ();

    usb_cdc_stream_bridge #(
        .OUT_DEPTH(OD), .IN_DEPTH(ID), .IN_BURST(IB), .IDLE_TIMEOUT(IT)
    ) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    typedef struct packed {
        logic       cfg;
        logic       cov;
        logic [7:0] cod;
        logic       aor;
        logic       aiv;
        logic [7:0] aid;
        logic       cir;
        logic       e_cor;
        logic       e_aov;
        logic [7:0] e_aod;
        logic       care_aod;
        logic       e_air;
        logic       e_civ;
        logic [3:0] e_ol;
        logic [3:0] e_il;
    } vec_t;

    vec_t tbl [20];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic quiet();
        bus.core_out_valid_i = 1'b0;
        bus.core_out_data_i  = 8'h00;
        bus.app_out_ready_i  = 1'b0;
        bus.app_in_valid_i   = 1'b0;
        bus.app_in_data_i    = 8'h00;
        bus.core_in_ready_i  = 1'b0;
    endtask

    logic [7:0] oq [$];
    logic [7:0] iq [$];

    initial begin
        int  o_tx, o_rx, i_tx, i_rx, cyc;
        bit  o_push, o_pop, i_push, i_pop;
        int  ol_before, il_before;

        // OUT fill to full, held-off 9th byte, then drain in order.
        for (int k = 0; k < 20; k++) begin
            tbl[k]       = '0;
            tbl[k].cfg   = 1'b1;
            tbl[k].e_air = 1'b1;
            tbl[k].e_cor = 1'b1;
            tbl[k].care_aod = 1'b1;
        end
        for (int k = 1; k <= 8; k++) begin
            tbl[k].cov   = 1'b1;
            tbl[k].cod   = 8'(k);
            tbl[k].e_aov = (k > 1);
            tbl[k].e_aod = (k > 1) ? 8'h01 : 8'h00;
            tbl[k].e_ol  = 4'(k - 1);
        end
        for (int k = 9; k <= 10; k++) begin
            tbl[k].cov   = 1'b1;
            tbl[k].cod   = 8'h09;
            tbl[k].e_cor = 1'b0;
            tbl[k].e_aov = 1'b1;
            tbl[k].e_aod = 8'h01;
            tbl[k].e_ol  = 4'd8;
        end
        for (int k = 11; k <= 18; k++) begin
            tbl[k].aor   = 1'b1;
            tbl[k].e_cor = (k != 11);
            tbl[k].e_aov = 1'b1;
            tbl[k].e_aod = 8'(k - 10);
            tbl[k].e_ol  = 4'(19 - k);
        end
        tbl[19].aor      = 1'b1;
        tbl[19].care_aod = 1'b0;

        bus.configured_i = 1'b0;
        quiet();
        #12 rstn_i = 1'b1;
        tick();

        // Reset state while still unconfigured.
        #1;
        chk("rst_core_out_ready", 32'(bus.core_out_ready_o), 0);
        chk("rst_app_in_ready",   32'(bus.app_in_ready_o), 0);
        chk("rst_app_out_valid",  32'(bus.app_out_valid_o), 0);
        chk("rst_core_in_valid",  32'(bus.core_in_valid_o), 0);
        chk("rst_app_out_data",   32'(bus.app_out_data_o), 0);
        chk("rst_core_in_data",   32'(bus.core_in_data_o), 0);
        chk("rst_out_level",      32'(bus.out_level_o), 0);
        chk("rst_in_level",       32'(bus.in_level_o), 0);

        for (int k = 0; k < 20; k++) begin
            bus.configured_i     = tbl[k].cfg;
            bus.core_out_valid_i = tbl[k].cov;
            bus.core_out_data_i  = tbl[k].cod;
            bus.app_out_ready_i  = tbl[k].aor;
            bus.app_in_valid_i   = tbl[k].aiv;
            bus.app_in_data_i    = tbl[k].aid;
            bus.core_in_ready_i  = tbl[k].cir;
            #1;
            chk($sformatf("tbl%0d_core_out_ready", k), 32'(bus.core_out_ready_o), 32'(tbl[k].e_cor));
            chk($sformatf("tbl%0d_app_out_valid", k),  32'(bus.app_out_valid_o),  32'(tbl[k].e_aov));
            if (tbl[k].care_aod)
                chk($sformatf("tbl%0d_app_out_data", k), 32'(bus.app_out_data_o), 32'(tbl[k].e_aod));
            chk($sformatf("tbl%0d_app_in_ready", k),   32'(bus.app_in_ready_o),   32'(tbl[k].e_air));
            chk($sformatf("tbl%0d_core_in_valid", k),  32'(bus.core_in_valid_o),  32'(tbl[k].e_civ));
            chk($sformatf("tbl%0d_out_level", k),      32'(bus.out_level_o),      32'(tbl[k].e_ol));
            chk($sformatf("tbl%0d_in_level", k),       32'(bus.in_level_o),       32'(tbl[k].e_il));
            tick();
        end

        // IN threshold: valid stays low through the 8th write, rises one cycle later.
        quiet();
        bus.core_in_ready_i = 1'b1;
        for (int k = 0; k < IB; k++) begin
            bus.app_in_valid_i = 1'b1;
            bus.app_in_data_i  = 8'(8'hA0 + k);
            #1;
            chk("thr_fill_valid", 32'(bus.core_in_valid_o), 0);
            chk("thr_fill_level", 32'(bus.in_level_o), 32'(k));
            chk("thr_fill_ready", 32'(bus.app_in_ready_o), 1);
            tick();
        end
        bus.app_in_valid_i = 1'b0;
        #1;
        chk("thr_gap_valid", 32'(bus.core_in_valid_o), 0);
        chk("thr_gap_level", 32'(bus.in_level_o), 8);
        tick();
        for (int k = 0; k < IB; k++) begin
            #1;
            chk("thr_drain_valid", 32'(bus.core_in_valid_o), 1);
            chk("thr_drain_data",  32'(bus.core_in_data_o), 32'(8'hA0 + k));
            chk("thr_drain_level", 32'(bus.in_level_o), 32'(IB - k));
            tick();
        end
        #1;
        chk("thr_end_valid", 32'(bus.core_in_valid_o), 0);
        chk("thr_end_level", 32'(bus.in_level_o), 0);

        // IN timeout: 3 bytes, then exactly IT idle cycles before the burst.
        for (int k = 0; k < 3; k++) begin
            bus.app_in_valid_i = 1'b1;
            bus.app_in_data_i  = 8'(8'hB0 + k);
            #1;
            chk("tmo_fill_valid", 32'(bus.core_in_valid_o), 0);
            tick();
        end
        bus.app_in_valid_i = 1'b0;
        for (int c = 0; c < IT; c++) begin
            #1;
            chk($sformatf("tmo_wait%0d_valid", c), 32'(bus.core_in_valid_o), 0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("tmo_drain_valid", 32'(bus.core_in_valid_o), 1);
            chk("tmo_drain_data",  32'(bus.core_in_data_o), 32'(8'hB0 + k));
            chk("tmo_drain_level", 32'(bus.in_level_o), 32'(3 - k));
            tick();
        end
        #1;
        chk("tmo_end_valid", 32'(bus.core_in_valid_o), 0);
        chk("tmo_end_level", 32'(bus.in_level_o), 0);

        // Random-stall traffic through both FIFOs against queue models.
        o_tx = 0; o_rx = 0; i_tx = 0; i_rx = 0; cyc = 0;
        while ((o_rx < NXFER || i_rx < NXFER) && cyc < 3000) begin
            bus.core_out_valid_i = (o_tx < NXFER) && ($urandom_range(0, 1) == 1);
            bus.core_out_data_i  = 8'(o_tx);
            bus.app_out_ready_i  = ($urandom_range(0, 1) == 1);
            bus.app_in_valid_i   = (i_tx < NXFER) && ($urandom_range(0, 1) == 1);
            bus.app_in_data_i    = 8'(8'h40 + i_tx);
            bus.core_in_ready_i  = ($urandom_range(0, 1) == 1);
            #1;
            chk("wrap_out_level", 32'(bus.out_level_o), 32'(oq.size()));
            chk("wrap_in_level",  32'(bus.in_level_o),  32'(iq.size()));
            chk("wrap_out_ready", 32'(bus.core_out_ready_o), 32'(oq.size() < OD));
            chk("wrap_in_ready",  32'(bus.app_in_ready_o),   32'(iq.size() < ID));
            chk("wrap_out_valid", 32'(bus.app_out_valid_o),  32'(oq.size() > 0));
            o_push = bus.core_out_valid_i && (oq.size() < OD);
            o_pop  = bus.app_out_ready_i && (oq.size() > 0);
            i_push = bus.app_in_valid_i && (iq.size() < ID);
            i_pop  = 1'b0;
            if (o_pop) chk("wrap_out_data", 32'(bus.app_out_data_o), 32'(oq[0]));
            if (bus.core_in_valid_o === 1'b1) begin
                chk("wrap_in_nonempty", 32'(iq.size() > 0), 1);
                if (iq.size() > 0) begin
                    chk("wrap_in_data", 32'(bus.core_in_data_o), 32'(iq[0]));
                    i_pop = bus.core_in_ready_i;
                end
            end
            ol_before = oq.size();
            il_before = iq.size();
            if (o_pop)  begin void'(oq.pop_front()); o_rx++; end
            if (o_push) begin oq.push_back(bus.core_out_data_i); o_tx++; end
            if (i_pop)  begin void'(iq.pop_front()); i_rx++; end
            if (i_push) begin iq.push_back(bus.app_in_data_i); i_tx++; end
            tick();
            if (o_push && o_pop) chk("wrap_out_sim_level", 32'(bus.out_level_o), 32'(ol_before));
            if (i_push && i_pop) chk("wrap_in_sim_level",  32'(bus.in_level_o),  32'(il_before));
            cyc++;
        end
        chk("wrap_out_count", 32'(o_rx), NXFER);
        chk("wrap_in_count",  32'(i_rx), NXFER);

        // Flush mid-drain with 5 IN bytes and 2 OUT bytes queued.
        quiet();
        for (int k = 0; k < IB; k++) begin
            bus.app_in_valid_i   = 1'b1;
            bus.app_in_data_i    = 8'(8'hC0 + k);
            bus.core_out_valid_i = (k < 2);
            bus.core_out_data_i  = 8'(8'hE0 + k);
            tick();
        end
        quiet();
        tick();
        #1;
        chk("fl_pre_valid", 32'(bus.core_in_valid_o), 1);
        chk("fl_pre_level", 32'(bus.in_level_o), 8);
        bus.core_in_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        bus.core_in_ready_i = 1'b0;
        #1;
        chk("fl_mid_in_level",  32'(bus.in_level_o), 5);
        chk("fl_mid_out_level", 32'(bus.out_level_o), 2);
        chk("fl_mid_valid",     32'(bus.core_in_valid_o), 1);
        bus.configured_i = 1'b0;
        tick();
        #1;
        chk("fl_out_level",      32'(bus.out_level_o), 0);
        chk("fl_in_level",       32'(bus.in_level_o), 0);
        chk("fl_core_out_ready", 32'(bus.core_out_ready_o), 0);
        chk("fl_app_in_ready",   32'(bus.app_in_ready_o), 0);
        chk("fl_app_out_valid",  32'(bus.app_out_valid_o), 0);
        chk("fl_core_in_valid",  32'(bus.core_in_valid_o), 0);
        bus.configured_i = 1'b1;
        #1;
        chk("fl_re_out_level",   32'(bus.out_level_o), 0);
        chk("fl_re_in_level",    32'(bus.in_level_o), 0);
        chk("fl_re_app_out_valid", 32'(bus.app_out_valid_o), 0);
        chk("fl_re_core_out_ready", 32'(bus.core_out_ready_o), 1);
        chk("fl_re_app_in_ready",  32'(bus.app_in_ready_o), 1);
        bus.app_in_valid_i  = 1'b1;
        bus.app_in_data_i   = 8'hD0;
        bus.core_in_ready_i = 1'b1;
        tick();
        bus.app_in_valid_i = 1'b0;
        #1;
        chk("fl_hold_valid", 32'(bus.core_in_valid_o), 0);
        chk("fl_hold_level", 32'(bus.in_level_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
